// File: rtl/char_physics.sv
// -----------------------------------------------------------------------------
// char_physics
//
// Per-frame movement of the player character: horizontal walking with
// saturation at the playfield edges, plus a three-phase vertical model
// (GROUNDED / RISING / FALLING) with jump impulse, gravity, fall-speed cap,
// ceiling clamp and floor clamp. Landing height comes from the platform stage
// (on_ground / ground_y). Everything outside play holds the start position.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame; all motion advances on it
//   btn_left     level, walk left
//   btn_right    level, walk right
//   btn_jump     level, jump request
//   game_active  2'd1 = play; any other value forces the start position
//   on_ground    landing flag from the platform stage
//   ground_y     snapped top-edge y from the platform stage
//   char_x       registered left edge
//   char_y       registered top edge
//   char_hgt     constant character size (width = height)
//   vel_y        registered unsigned vertical speed magnitude
//   phase        registered motion phase: 0 GROUNDED, 1 RISING, 2 FALLING
//   facing       registered direction: 0 right, 1 left
// -----------------------------------------------------------------------------
module char_physics #(
    parameter logic [11:0] X_START   = 12'd100,
    parameter logic [11:0] Y_START   = 12'd100,
    parameter logic [11:0] CHAR_HGT  = 12'd64,
    parameter logic [11:0] X_MAX     = 12'd960,
    parameter logic [11:0] Y_MAX     = 12'd704,
    parameter int          MOVE_STEP = 4,
    parameter int          JUMP_VEL  = 12,
    parameter int          GRAVITY   = 1,
    parameter int          MAX_FALL  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic [1:0]  game_active,
    input  logic        on_ground,
    input  logic [11:0] ground_y,
    output logic [11:0] char_x,
    output logic [11:0] char_y,
    output logic [11:0] char_hgt,
    output logic [4:0]  vel_y,
    output logic [1:0]  phase,
    output logic        facing
);

    localparam logic [11:0] STEP_12 = 12'(MOVE_STEP);
    localparam logic [4:0]  JUMP_5  = 5'(JUMP_VEL);
    localparam logic [4:0]  GRAV_5  = 5'(GRAVITY);
    localparam logic [4:0]  MAXF_5  = 5'(MAX_FALL);

    typedef enum logic [1:0] {
        PH_GROUNDED = 2'd0,
        PH_RISING   = 2'd1,
        PH_FALLING  = 2'd2,
        PH_UNUSED   = 2'd3
    } phase_t;

    logic [11:0] r_x;
    logic [11:0] r_y;
    logic [4:0]  r_vel;
    phase_t      r_phase;
    logic        r_facing;

    logic [11:0] w_x_nxt;
    logic [11:0] w_y_nxt;
    logic [4:0]  w_vel_nxt;
    phase_t      w_phase_nxt;
    logic        w_facing_nxt;

    // One extra bit on every sum/difference so overflow and underflow are
    // detected explicitly instead of wrapping.
    logic [12:0] w_x_sum;
    logic [12:0] w_y_sum;
    logic [12:0] w_y_diff;
    logic [5:0]  w_vel_inc;
    logic [5:0]  w_vel_dec;
    logic        w_play;

    assign w_x_sum   = {1'b0, r_x} + {1'b0, STEP_12};
    assign w_y_sum   = {1'b0, r_y} + {8'd0, r_vel};
    assign w_y_diff  = {1'b0, r_y} - {8'd0, r_vel};
    assign w_vel_inc = {1'b0, r_vel} + {1'b0, GRAV_5};
    assign w_vel_dec = {1'b0, r_vel} - {1'b0, GRAV_5};
    assign w_play    = (game_active == 2'd1);

    assign char_x   = r_x;
    assign char_y   = r_y;
    assign char_hgt = CHAR_HGT;
    assign vel_y    = r_vel;
    assign phase    = r_phase;
    assign facing   = r_facing;

    // State register. Leaving play reloads the start values on any edge,
    // without waiting for a frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= X_START;
            r_y      <= Y_START;
            r_vel    <= 5'd0;
            r_phase  <= PH_FALLING;
            r_facing <= 1'b0;
        end else if (!w_play) begin
            r_x      <= X_START;
            r_y      <= Y_START;
            r_vel    <= 5'd0;
            r_phase  <= PH_FALLING;
            r_facing <= 1'b0;
        end else if (frame_tick) begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_vel    <= w_vel_nxt;
            r_phase  <= w_phase_nxt;
            r_facing <= w_facing_nxt;
        end
    end

    // Next-state for one frame of motion.
    always_comb begin
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_vel_nxt    = r_vel;
        w_phase_nxt  = r_phase;
        w_facing_nxt = r_facing;

        // Horizontal: independent of phase; both buttons cancel out.
        if (btn_left && !btn_right) begin
            w_facing_nxt = 1'b1;
            w_x_nxt      = (r_x < STEP_12) ? 12'd0 : (r_x - STEP_12);
        end else if (btn_right && !btn_left) begin
            w_facing_nxt = 1'b0;
            w_x_nxt      = (w_x_sum > {1'b0, X_MAX}) ? X_MAX : w_x_sum[11:0];
        end

        case (r_phase)
            PH_GROUNDED: begin
                if (btn_jump && on_ground) begin
                    // y stays put this frame; the first step happens in RISING.
                    w_phase_nxt = PH_RISING;
                    w_vel_nxt   = JUMP_5;
                end else if (!on_ground) begin
                    w_phase_nxt = PH_FALLING;
                    w_vel_nxt   = 5'd0;
                end else begin
                    w_y_nxt   = ground_y;
                    w_vel_nxt = 5'd0;
                end
            end
            PH_RISING: begin
                // on_ground deliberately ignored: platforms only catch a falling body.
                if (w_y_diff[12]) begin
                    // Speed larger than distance to the top: clamp at the ceiling.
                    w_y_nxt     = 12'd0;
                    w_vel_nxt   = 5'd0;
                    w_phase_nxt = PH_FALLING;
                end else begin
                    w_y_nxt = w_y_diff[11:0];
                    if (w_vel_dec[5] || (w_vel_dec[4:0] == 5'd0)) begin
                        w_vel_nxt   = 5'd0;
                        w_phase_nxt = PH_FALLING;
                    end else begin
                        w_vel_nxt = w_vel_dec[4:0];
                    end
                end
            end
            PH_FALLING: begin
                // A landing frame never also consumes the jump button, so a
                // held jump waits at least one GROUNDED frame.
                if (on_ground) begin
                    w_y_nxt     = ground_y;
                    w_vel_nxt   = 5'd0;
                    w_phase_nxt = PH_GROUNDED;
                end else if (w_y_sum >= {1'b0, Y_MAX}) begin
                    w_y_nxt     = Y_MAX;
                    w_vel_nxt   = 5'd0;
                    w_phase_nxt = PH_GROUNDED;
                end else begin
                    w_y_nxt   = w_y_sum[11:0];
                    w_vel_nxt = (w_vel_inc > {1'b0, MAXF_5}) ? MAXF_5 : w_vel_inc[4:0];
                end
            end
            default: begin
                w_phase_nxt = PH_FALLING;
            end
        endcase
    end

endmodule

// File: doc/char_physics.md
CHAR_PHYSICS -- requirements
Module: char_physics

Interface
REQ-001 Parameters SHALL be:
- X_START, default 12'd100: x after reset or outside play.
- Y_START, default 12'd100: y after reset or outside play.
- CHAR_HGT, default 12'd64: character height and width in pixels.
- X_MAX, default 12'd960: largest legal char_x.
- Y_MAX, default 12'd704: largest legal char_y.
- MOVE_STEP, default 4: horizontal pixels per frame.
- JUMP_VEL, default 12: initial upward speed in px/frame.
- GRAVITY, default 1: speed change per frame.
- MAX_FALL, default 5: fall speed cap; must not exceed the 6-pixel landing window of the platform stage.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- btn_left  in  1  level; move left.
- btn_right  in  1  level; move right.
- btn_jump  in  1  level; request jump.
- game_active  in  2  1 means play; any other value means menu or over.
- on_ground  in  1  landing flag from the platform stage.
- ground_y  in  12  snapped y from the platform stage.
- char_x  out  12  registered character left edge.
- char_y  out  12  registered character top edge.
- char_hgt  out  12  constant CHAR_HGT.
- vel_y  out  5  registered unsigned speed magnitude.
- phase  out  2  registered state: 0 GROUNDED, 1 RISING, 2 FALLING.
- facing  out  1  registered direction: 0 right, 1 left.

Function
REQ-003 All outputs except char_hgt SHALL be registered on clk.
REQ-004 State and outputs SHALL change only on a clk edge where frame_tick=1, except as REQ-005 states.
REQ-005 On any edge where game_active!=1, the block SHALL load char_x=X_START, char_y=Y_START, vel_y=0, phase=FALLING and facing=0, regardless of frame_tick.
REQ-006 Horizontal, per tick:
- btn_left only: char_x -= MOVE_STEP, saturating at 0; facing=1.
- btn_right only: char_x += MOVE_STEP, saturating at X_MAX; facing=0.
- both or neither pressed: char_x and facing unchanged.
REQ-007 Horizontal update SHALL apply in every phase, in the same tick as the vertical update.
REQ-008 GROUNDED, per tick:
- btn_jump=1 and on_ground=1: go to RISING, vel_y=JUMP_VEL, char_y unchanged.
- on_ground=0: go to FALLING, vel_y=0.
- otherwise: char_y=ground_y, vel_y=0.
REQ-009 RISING, per tick:
- If vel_y>char_y: char_y=0, vel_y=0, go to FALLING (ceiling clamp).
- Else: char_y -= vel_y, vel_y -= GRAVITY.
- When the decremented vel_y is 0, go to FALLING.
REQ-010 RISING SHALL ignore on_ground.
REQ-011 FALLING, per tick:
- on_ground=1: char_y=ground_y, vel_y=0, go to GROUNDED; no y step that tick.
- Else: char_y=min(char_y+vel_y, Y_MAX), vel_y=min(vel_y+GRAVITY, MAX_FALL).
- When char_y reaches Y_MAX: also go to GROUNDED, vel_y=0.
REQ-012 Holding btn_jump SHALL NOT start a second jump until the block has passed through GROUNDED for at least one tick after a landing (no auto-repeat within the landing tick).
REQ-013 All y arithmetic SHALL be unsigned, 13 bits internally with an explicit carry/borrow check; no wrap-around.
REQ-014 An unused phase encoding (3) SHALL recover to FALLING on the next tick.
REQ-015 vel_y SHALL never exceed max(JUMP_VEL, MAX_FALL).

Reset
REQ-016 With rst_n=0, the block SHALL immediately (asynchronously) set char_x=X_START, char_y=Y_START, vel_y=0, phase=FALLING and facing=0.
REQ-017 Release of rst_n mid-frame SHALL take no action until the next frame_tick.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset: hold rst_n=0 while frame_tick pulses, then release -> outputs (100,100,0,FALLING); first tick without on_ground -> char_y=100, vel_y=1.
- Fall and land: from FALLING, 10 ticks with on_ground=0 -> vel_y saturates at 5; then on_ground=1 with ground_y=400 -> char_y=400, phase=GROUNDED, vel_y=0.
- Jump arc: GROUNDED at y=400, btn_jump for one tick -> RISING, vel_y=12; per-tick y = 388, 377, 367, ...; FALLING after 12 ticks at y=322.
- Ceiling: RISING with char_y=5 and vel_y=9 -> char_y=0, vel_y=0, phase=FALLING.
- Horizontal edges: char_x=2 with btn_left -> 0 and facing=1; char_x=958 with btn_right -> 960; both buttons pressed -> char_x unchanged.
- Game inactive: game_active=2 mid-jump -> next clk (no tick needed) loads the start values; no update while inactive even with ticks and buttons.
